// File: rtl/mnist_frame_gate.sv
// mnist_frame_gate: admits or discards whole video frames ahead of the LUT-CNN core
// based on enable and the number of frames in flight. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module mnist_frame_gate #(
  parameter int TUSER_WIDTH    = 1,
  parameter int TDATA_WIDTH    = 1,
  parameter int LINE_WIDTH     = 10,
  parameter int INFLIGHT_WIDTH = 2,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [INFLIGHT_WIDTH-1:0] param_max_inflight,
  input  logic [LINE_WIDTH-1:0]     param_out_lines,
  input  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser,
  input  logic                      s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]    s_axi4s_tdata,
  input  logic                      s_axi4s_tvalid,
  output logic                      s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
  output logic                      m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]    m_axi4s_tdata,
  output logic                      m_axi4s_tvalid,
  input  logic                      m_axi4s_tready,
  input  logic                      mon_tlast,
  input  logic                      mon_tvalid,
  input  logic                      mon_tready,
  output logic [INFLIGHT_WIDTH-1:0] stat_inflight,
  output logic [STAT_WIDTH-1:0]     stat_pass_frames,
  output logic [STAT_WIDTH-1:0]     stat_drop_frames,
  output logic                      stat_underflow
);

  localparam int PW = TUSER_WIDTH + 1 + TDATA_WIDTH;
  localparam logic [LINE_WIDTH-1:0]     c_LINE_ONE = LINE_WIDTH'(1);
  localparam logic [INFLIGHT_WIDTH-1:0] c_INF_ONE  = INFLIGHT_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0]     c_STAT_ONE = STAT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      rdy_q, rdy_d;
  logic [LINE_WIDTH-1:0]     line_q, line_d;
  logic [INFLIGHT_WIDTH-1:0] infl_q, infl_d;
  logic [STAT_WIDTH-1:0]     pass_q, pass_d, drop_q, drop_d;
  logic                      unf_q, unf_d;

  logic                      acc, sof, mon_beat, dec, admit, inc, fwd, push, pop;
  logic [LINE_WIDTH-1:0]     line_last;
  logic [INFLIGHT_WIDTH-1:0] max_eff, infl_after_dec;
  logic [1:0]                wr_idx;
  logic [PW-1:0]             s_payload;

  always_comb begin
    acc       = s_axi4s_tvalid & rdy_q;
    sof       = acc & s_axi4s_tuser[0];
    s_payload = {s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata};

    mon_beat  = mon_tvalid & mon_tready & mon_tlast;
    line_last = (param_out_lines == '0) ? '0 : param_out_lines - c_LINE_ONE;
    dec       = mon_beat & (line_q == line_last);
    line_d    = line_q;
    if (dec)           line_d = '0;
    else if (mon_beat) line_d = line_q + c_LINE_ONE;

    // Admission sees the count as it will be after this cycle's completion.
    max_eff        = (param_max_inflight == '0) ? c_INF_ONE : param_max_inflight;
    infl_after_dec = (dec && infl_q != '0) ? infl_q - c_INF_ONE : infl_q;
    admit          = enable & (infl_after_dec < max_eff);
    inc            = sof & admit;
    fwd            = sof ? admit : (state_q == ST_PASS);

    state_d = state_q;
    if (sof) state_d = admit ? ST_PASS : ST_DROP;

    infl_d = infl_q;
    unf_d  = unf_q;
    case ({inc, dec})
      2'b10: infl_d = infl_q + c_INF_ONE;
      2'b01: begin
        if (infl_q == '0) unf_d = 1'b1;
        else              infl_d = infl_q - c_INF_ONE;
      end
      default: infl_d = infl_q;
    endcase

    pass_d = inc ? pass_q + c_STAT_ONE : pass_q;
    drop_d = (sof & ~admit) ? drop_q + c_STAT_ONE : drop_q;

    // Two-entry buffer: entry 0 is the head driving the core port.
    push   = acc & fwd;
    pop    = (cnt_q != 2'd0) & m_axi4s_tready;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) buf0_d = buf1_q;
    wr_idx = cnt_q - {1'b0, pop};
    if (push) begin
      if (wr_idx == 2'd0) buf0_d = s_payload;
      else                buf1_d = s_payload;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= 2'd0;
      rdy_q   <= 1'b0;
      line_q  <= '0;
      infl_q  <= '0;
      pass_q  <= '0;
      drop_q  <= '0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      line_q  <= line_d;
      infl_q  <= infl_d;
      pass_q  <= pass_d;
      drop_q  <= drop_d;
      unf_q   <= unf_d;
    end
  end

  assign s_axi4s_tready = rdy_q;
  assign {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} = buf0_q;
  assign m_axi4s_tvalid   = (cnt_q != 2'd0);
  assign stat_inflight    = infl_q;
  assign stat_pass_frames = pass_q;
  assign stat_drop_frames = drop_q;
  assign stat_underflow   = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_mnist_frame_gate.sv
// tb_mnist_frame_gate: directed vectors with hand-computed expectations for mnist_frame_gate.
`timescale 1ns/1ps
`default_nettype none

module tb_mnist_frame_gate;

  localparam int TUW = 1;
  localparam int TDW = 1;
  localparam int LW  = 10;
  localparam int IW  = 2;
  localparam int SW  = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [IW-1:0]  param_max_inflight = '0;
  logic [LW-1:0]  param_out_lines = '0;
  logic [TUW-1:0] s_axi4s_tuser = '0;
  logic           s_axi4s_tlast = 1'b0;
  logic [TDW-1:0] s_axi4s_tdata = '0;
  logic           s_axi4s_tvalid = 1'b0;
  logic           s_axi4s_tready;
  logic [TUW-1:0] m_axi4s_tuser;
  logic           m_axi4s_tlast;
  logic [TDW-1:0] m_axi4s_tdata;
  logic           m_axi4s_tvalid;
  logic           m_axi4s_tready = 1'b1;
  logic           mon_tlast = 1'b0;
  logic           mon_tvalid = 1'b0;
  logic           mon_tready = 1'b0;
  logic [IW-1:0]  stat_inflight;
  logic [SW-1:0]  stat_pass_frames;
  logic [SW-1:0]  stat_drop_frames;
  logic           stat_underflow;

  mnist_frame_gate #(
    .TUSER_WIDTH(TUW), .TDATA_WIDTH(TDW), .LINE_WIDTH(LW),
    .INFLIGHT_WIDTH(IW), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .param_max_inflight(param_max_inflight), .param_out_lines(param_out_lines),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
    .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready),
    .mon_tlast(mon_tlast), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .stat_inflight(stat_inflight), .stat_pass_frames(stat_pass_frames),
    .stat_drop_frames(stat_drop_frames), .stat_underflow(stat_underflow)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  logic       bp_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Beat payload {tuser, tlast, tdata} for pixel i of a w-wide frame.
  function automatic logic [2:0] pix(input int i, input int w, input int seed);
    int t;
    t = (i * 5 + seed) >> 1;
    return {logic'(i == 0), logic'((i % w) == w - 1), t[0]};
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    m_axi4s_tready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  logic       prev_stall = 1'b0;
  logic [2:0] prev_pl = '0;
  always @(negedge clk) begin : m_monitor
    logic [2:0] pl;
    pl = {m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata[0]};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_axi4s_tvalid, 1);
        chk("hold_data", pl, prev_pl);
      end
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat_valid", m_axi4s_tvalid, 0);
        else                   chk("beat", pl, exp_q.pop_front());
      end
      prev_stall = m_axi4s_tvalid && !m_axi4s_tready;
      prev_pl    = pl;
    end
  end

  task automatic send_frame(input int w, input int first, input int last, input bit fwd,
                            input int seed, input int tog_idx, input bit tog_val,
                            input bit mon_sof);
    for (int i = first; i <= last; i++) begin
      logic [2:0] p;
      bit         acc;
      p = pix(i, w, seed);
      if (i == tog_idx) enable = tog_val;
      s_axi4s_tuser  = p[2];
      s_axi4s_tlast  = p[1];
      s_axi4s_tdata  = p[0];
      s_axi4s_tvalid = 1'b1;
      if (mon_sof && i == first) begin
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
      end
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
        @(negedge clk);
        if (!fwd && k == 0) chk("drop_tready", s_axi4s_tready, 1);
        if (s_axi4s_tready) begin
          acc = 1'b1;
          if (fwd) exp_q.push_back(p);
        end
        @(posedge clk);
        #1;
      end
      if (!acc) chk("accept_timeout", acc, 1);
      mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    end
    s_axi4s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mon_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
      @(posedge clk); #1;
      mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", s_axi4s_tready, 0);
    chk("rst_m_tvalid", m_axi4s_tvalid, 0);
    chk("rst_pass", stat_pass_frames, 0);
    chk("rst_drop", stat_drop_frames, 0);
    chk("rst_inflight", stat_inflight, 0);
    chk("rst_underflow", stat_underflow, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_rst", s_axi4s_tready, 1);

    // Basic pass
    enable = 1'b1; param_max_inflight = 2'd2; param_out_lines = 10'd3;
    send_frame(4, 0, 15, 1, 0, -1, 0, 0);
    wait_drain();
    chk("basic_pass", stat_pass_frames, 1);
    chk("basic_drop", stat_drop_frames, 0);
    chk("basic_inflight", stat_inflight, 1);
    mon_pulse(2);
    chk("basic_inflight_2lines", stat_inflight, 1);
    mon_pulse(1);
    chk("basic_inflight_done", stat_inflight, 0);
    chk("basic_underflow", stat_underflow, 0);

    // Saturation drop
    param_max_inflight = 2'd1;
    send_frame(4, 0, 15, 1, 1, -1, 0, 0);
    send_frame(4, 0, 15, 0, 2, -1, 0, 0);
    send_frame(4, 0, 15, 0, 3, -1, 0, 0);
    wait_drain();
    chk("sat_pass", stat_pass_frames, 2);
    chk("sat_drop", stat_drop_frames, 2);
    chk("sat_inflight", stat_inflight, 1);

    // Completion coincides with the next SOF
    mon_pulse(2);
    chk("sim_inflight_pre", stat_inflight, 1);
    send_frame(4, 0, 15, 1, 4, -1, 0, 1);
    wait_drain();
    chk("sim_pass", stat_pass_frames, 3);
    chk("sim_drop", stat_drop_frames, 2);
    chk("sim_inflight", stat_inflight, 1);
    chk("sim_underflow", stat_underflow, 0);

    // Enable only takes effect at SOF
    param_max_inflight = 2'd2;
    send_frame(4, 0, 15, 1, 5, 8, 0, 0);
    send_frame(4, 0, 15, 0, 6, -1, 0, 0);
    send_frame(4, 0, 15, 0, 7, 5, 1, 0);
    wait_drain();
    chk("en_pass", stat_pass_frames, 4);
    chk("en_drop", stat_drop_frames, 4);
    chk("en_inflight", stat_inflight, 2);
    mon_pulse(6);
    chk("en_inflight_done", stat_inflight, 0);
    chk("en_underflow", stat_underflow, 0);

    // Backpressure over a 28x28 frame
    bp_mode = 1'b1;
    send_frame(28, 0, 783, 1, 8, -1, 0, 0);
    wait_drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("bp_pass", stat_pass_frames, 5);
    chk("bp_inflight", stat_inflight, 1);

    // Underflow
    mon_pulse(3);
    chk("unf_inflight0", stat_inflight, 0);
    chk("unf_not_yet", stat_underflow, 0);
    mon_pulse(3);
    chk("unf_set", stat_underflow, 1);
    chk("unf_inflight", stat_inflight, 0);

    // Reset in the middle of a frame
    send_frame(4, 0, 9, 1, 9, -1, 0, 0);
    chk("pre_rst_m_tvalid", m_axi4s_tvalid, 1);
    chk("pre_rst_pass", stat_pass_frames, 6);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_m_tvalid", m_axi4s_tvalid, 0);
    chk("mid_rst_m_payload", {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, 0);
    chk("mid_rst_s_tready", s_axi4s_tready, 0);
    chk("mid_rst_pass", stat_pass_frames, 0);
    chk("mid_rst_drop", stat_drop_frames, 0);
    chk("mid_rst_inflight", stat_inflight, 0);
    chk("mid_rst_underflow", stat_underflow, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_frame(4, 10, 15, 0, 9, -1, 0, 0);
    repeat (4) @(posedge clk); #1;
    chk("post_rst_drop", stat_drop_frames, 0);
    chk("post_rst_pass", stat_pass_frames, 0);
    send_frame(4, 0, 15, 1, 10, -1, 0, 0);
    wait_drain();
    chk("post_rst_frame_pass", stat_pass_frames, 1);
    chk("post_rst_frame_inflight", stat_inflight, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mnist_frame_gate.md
# mnist_frame_gate

Frame-admission controller placed in front of the MNIST LUT-CNN core. It decides, at each start-of-frame, whether the whole incoming video frame is forwarded to the core or discarded. The decision is based on an enable input and on how many frames are currently in flight inside the three-layer convolution pipeline. Frame completion is tracked by monitoring the core's output stream handshake, and per-frame pass/drop statistics are exported.

## Interface
- TUSER_WIDTH, 1, AXI4-Stream tuser width; bit 0 is start-of-frame (SOF).
- TDATA_WIDTH, 1, pixel data width on both stream ports.
- LINE_WIDTH, 10, width of the output line counter and `param_out_lines`.
- INFLIGHT_WIDTH, 2, width of the in-flight counter and `param_max_inflight`.
- STAT_WIDTH, 16, width of the frame statistics counters.
- Ports:
  - clk  in  1  clock.
  - reset  in  1  asynchronous reset, active-high.
  - enable  in  1  admit frames when 1; sampled only on SOF beats.
  - param_max_inflight  in  INFLIGHT_WIDTH  maximum frames allowed inside the core; 0 is treated as 1.
  - param_out_lines  in  LINE_WIDTH  tlast beats per core output frame; 0 is treated as 1.
  - s_axi4s_tuser / tlast / tdata / tvalid  in  TUSER_WIDTH / 1 / TDATA_WIDTH / 1  input video stream.
  - s_axi4s_tready  out  1  input ready.
  - m_axi4s_tuser / tlast / tdata / tvalid  out  TUSER_WIDTH / 1 / TDATA_WIDTH / 1  stream to the core.
  - m_axi4s_tready  in  1  core ready.
  - mon_tlast, mon_tvalid, mon_tready  in  1 each  observed core output handshake (read-only tap).
  - stat_inflight  out  INFLIGHT_WIDTH  current in-flight frame count.
  - stat_pass_frames  out  STAT_WIDTH  frames forwarded; wraps.
  - stat_drop_frames  out  STAT_WIDTH  frames discarded; wraps.
  - stat_underflow  out  1  sticky; set when a frame completes while in-flight is 0.

## Operation
- **Input acceptance.** An input beat is accepted on `s_axi4s_tvalid & s_axi4s_tready`. A SOF beat is an accepted beat with `s_axi4s_tuser[0]=1`.
- **State machine** (reset state IDLE):
  - IDLE: discard beats until the first SOF.
  - PASS: forward beats.
  - DROP: discard beats.
- **Transitions.** The decision is made on every SOF beat, in any state, and that SOF beat itself belongs to the new frame.
  - Go to PASS if `enable` and `(inflight - dec) < max_eff`; otherwise go to DROP.
  - `dec` is a frame completion in the same cycle.
  - `max_eff` is `max(param_max_inflight, 1)`.
  - Non-SOF beats never change state. Changing `enable` mid-frame has no effect until the next SOF.
- **Forward path.** Beats accepted while in PASS (including the admitting SOF beat) are written into a 2-entry skid buffer that drives `m_axi4s_*`. Discarded beats are not written.
- **Ready.** `s_axi4s_tready` is the registered "buffer has a free entry" flag. It is independent of the state, so dropped beats are consumed at the same rate as forwarded ones.
- **Completion tracking.**
  - The line counter increments on `mon_tvalid & mon_tready & mon_tlast`.
  - When it reaches `max(param_out_lines,1)-1` on such a beat, it clears to 0 and raises `dec` for one cycle.
- **In-flight counter.** `inflight += inc - dec`, where `inc` is an admitting SOF beat.
  - Simultaneous `inc` and `dec` leave the count unchanged.
  - `dec` with inflight=0 and no `inc` leaves the count at 0 and sets `stat_underflow`.
  - `inc` at the counter maximum cannot occur, because admission guarantees it stays below `max_eff`.
- **Statistics.** `stat_pass_frames` increments on each admitting SOF. `stat_drop_frames` increments on each rejecting SOF. Both wrap modulo 2^STAT_WIDTH.

## Timing
- **Reset values.** All outputs and internal registers are 0, including:
  - `s_axi4s_tready`, `m_axi4s_tvalid`, state=IDLE, and all counters and statistics.
  - `s_axi4s_tready` rises on the first clk edge after `reset` deasserts.
- **Latency.** A forwarded beat appears on `m_axi4s_*` 1 cycle after acceptance when the buffer is empty. Throughput is 1 beat/cycle while `m_axi4s_tready=1`.
- **Backpressure.**
  - `m_axi4s_tvalid` and the `m_axi4s_*` payload hold stable until `m_axi4s_tready`.
  - `s_axi4s_tready` falls the cycle after the buffer becomes full, and the second entry absorbs the beat in flight.
  - No beat is lost or duplicated.
- **Status timing.** `stat_*` update on the clock edge after the causing handshake. The pass/drop decision uses the combinational `dec` of the same cycle.
- **Reset mid-frame.** State returns to IDLE and the buffer is flushed. The remainder of the current input frame is discarded until the next SOF.

## Test plan
- **Basic pass.** Reset, enable=1, max=2, out_lines=3; send one 4x4 frame.
  - Expect 16 beats on m with identical data, tuser and tlast.
  - Expect stat_pass=1 and inflight=1.
  - After 3 mon tlast beats, expect inflight=0.
- **Saturation drop.** max=1; send 3 back-to-back frames with no mon activity.
  - Expect frame 1 passed and frames 2–3 dropped.
  - Expect stat_pass=1, stat_drop=2, and s_tready to stay high during the drops.
- **Simultaneous inc/dec.** inflight=1, max=1; the third mon tlast beat coincides with the next SOF beat.
  - Expect the frame to be admitted and inflight to remain 1.
- **Enable timing.** Drop enable mid-frame.
  - Expect the current frame to be completely forwarded and the next SOF to be dropped.
  - Re-raise enable mid-frame: expect that frame to be still dropped.
- **Backpressure.** Apply random m_tready at 30% duty over a 28x28 frame.
  - Expect all 784 beats in order, with m_* stable while stalled.
- **Underflow and reset.** Pulse 3 mon tlast beats with inflight=0: expect stat_underflow=1.
  - Assert reset mid-frame: expect all outputs to return to 0 and the remaining beats, up to the next SOF, to be discarded.
